dmg_irq_ctrl: RTL
=================

# dmg_irq_ctrl

Interrupt controller for the DMG CPU core. It latches the five peripheral interrupt requests into IF and holds the IE mask and the IME master enable, including the delayed effect of EI. It raises the wake and pending signals consumed by the sequencer and supplies the dispatch vector through a two-phase acknowledge handshake. It sits between the peripheral request lines and the sequencer, with IF/IE exposed on the CPU register bus.

## Interface
- No parameters. Source count (5) and vector constants are fixed in the package.
- `CLK  in  1`  core clock; all state updates on its rising edge.
- `nRESET  in  1`  reset, synchronous, active-low.
- `IRQ_REQ  in  5`  single-cycle request pulses: [0] VBlank, [1] STAT, [2] Timer, [3] Serial, [4] Joypad.
- `REG_SEL  in  1`  register select: 0 = IF (FF0F), 1 = IE (FFFF).
- `REG_WR  in  1`  write strobe; writes `REG_WDATA` to the selected register.
- `REG_WDATA  in  8`  write data.
- `REG_RDATA  out  8`  read data. Combinational. IF reads as {3'b111, IF[4:0]}; IE reads all 8 stored bits.
- `EI  in  1`  pulse from the EI instruction.
- `DI  in  1`  pulse from the DI instruction.
- `RETI  in  1`  pulse from the RETI instruction.
- `INSTR_DONE  in  1`  pulse at each instruction boundary.
- `INT_ACK  in  1`  sequencer begins dispatch (phase 1).
- `VEC_REQ  in  1`  sequencer requests the vector (phase 2).
- `INT_PEND  out  1`  IME & |(IF & IE[4:0]) & state==IDLE.
- `WAKE  out  1`  |(IF & IE[4:0]), independent of IME; used as the HALT exit.
- `STOP_WAKE  out  1`  IRQ_REQ[4] passed through unregistered, for STOP exit.
- `VECTOR  out  8`  dispatch vector low byte; holds its value until the next VECOUT.
- `VEC_VALID  out  1`  one-cycle strobe qualifying VECTOR.

## Operation
- Reset values:
  - IF = 0, IE = 0, IME = 0, ei_armed = 0.
  - State = IDLE, VECTOR = 8'h00, VEC_VALID = 0.
  - INT_PEND = 0, WAKE = 0.
- IF update, evaluated per bit each cycle:
  - next = (REG_WR & !REG_SEL ? WDATA[i] : IF[i]), then cleared if dispatch selects bit i, then OR IRQ_REQ[i].
  - A new request always wins over a write clear and over a dispatch clear in the same cycle.
- IE is a plain 8-bit register, written when REG_WR & REG_SEL.
- IME:
  - DI clears IME and ei_armed.
  - RETI sets IME and clears ei_armed.
  - EI sets ei_armed. The first INSTR_DONE in a cycle strictly after the EI cycle sets IME and clears ei_armed.
  - INT_ACK clears IME and ei_armed.
  - Priority when pulses coincide: INT_ACK > DI > RETI > EI > armed promotion.
- State machine (IDLE, ACKED, VECOUT):
  - IDLE -> ACKED on INT_ACK. INT_ACK is ignored unless INT_PEND = 1.
  - ACKED -> VECOUT on VEC_REQ. In that cycle, select the lowest set bit of IF & IE[4:0] using pre-edge values and clear it in IF. VECTOR <= 8'h40 + 8·index.
  - If nothing is pending at VEC_REQ (IE or IF rewritten during dispatch), VECTOR <= 8'h00 and no IF bit is cleared.
  - VECOUT: VEC_VALID = 1 for exactly one cycle, then return to IDLE.
- nRESET low in any state forces the reset values on the next edge. Any dispatch in progress is abandoned and VEC_VALID is not produced.

## Timing
- IRQ_REQ pulse in cycle n: IF bit visible on REG_RDATA, WAKE and INT_PEND in cycle n+1.
- Register write in cycle n is visible in cycle n+1. A write coincident with VEC_REQ does not affect that cycle's selection.
- VEC_REQ in cycle n: VEC_VALID and the new VECTOR in cycle n+1. The IF bit is cleared in cycle n+1.
- INT_PEND falls in the cycle after INT_ACK, because IME is cleared and state leaves IDLE.
- EI in cycle n with INSTR_DONE in the same cycle n: no effect. The next INSTR_DONE at cycle m > n makes IME = 1 in cycle m+1.

## Structure
- Package `dmg_irq_pkg` holds:
  - source index constants (IRQ_VBLANK .. IRQ_JOYPAD);
  - vector constants 8'h40/48/50/58/60 and VEC_CANCEL = 8'h00;
  - register selects REG_IF, REG_IE;
  - state enum {IDLE, ACKED, VECOUT}.
- One combinational sub-module `dmg_irq_prio` takes the 5-bit pending vector and returns {any, index[2:0]}. It is reused by the vector select.

## Test plan
- Reset, write IE = 8'h1F, IME = 1 via RETI, pulse IRQ_REQ = 5'b10100 -> INT_PEND = 1; INT_ACK, VEC_REQ -> VECTOR = 8'h50, IF reads 8'hF0.
- With IF pending, pulse EI, then INSTR_DONE in the same cycle -> INT_PEND stays 0; the next INSTR_DONE -> INT_PEND = 1 one cycle later.
- After INT_ACK, write IE = 8'h00 before VEC_REQ -> VECTOR = 8'h00, VEC_VALID = 1, IF unchanged.
- Write IF = 8'h00 in the same cycle as IRQ_REQ[2] -> IF reads 8'hE4 next cycle.
- IME = 0, IE[0] = 1, IRQ_REQ[0] -> WAKE = 1, INT_PEND = 0. Assert nRESET = 0 during ACKED -> IDLE, IF = 0, IE = 0, no VEC_VALID.

Source files
------------

// File: rtl/dmg_irq_pkg.sv
// Shared constants, state encoding and vector helper for the DMG interrupt controller.
package dmg_irq_pkg;

    localparam int IRQ_NUM    = 5;

    // Request source indices, lowest index has highest priority
    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    // Dispatch vector low bytes
    localparam logic [7:0] VEC_VBLANK = 8'h40;
    localparam logic [7:0] VEC_STAT   = 8'h48;
    localparam logic [7:0] VEC_TIMER  = 8'h50;
    localparam logic [7:0] VEC_SERIAL = 8'h58;
    localparam logic [7:0] VEC_JOYPAD = 8'h60;
    localparam logic [7:0] VEC_CANCEL = 8'h00;

    // Register bus selects
    localparam logic REG_IF = 1'b0;
    localparam logic REG_IE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACKED  = 2'd1,
        VECOUT = 2'd2
    } irq_state_t;

    // Vector for a source index: base plus eight bytes per source
    function automatic logic [7:0] irq_vector(input logic [2:0] idx);
        return VEC_VBLANK + {2'b00, idx, 3'b000};
    endfunction

endpackage

// File: rtl/dmg_irq_prio.sv
// Fixed-priority encoder: reports whether any source is pending and the lowest pending index.
module dmg_irq_prio
    import dmg_irq_pkg::*;
(
    input  logic [IRQ_NUM-1:0] pend,
    output logic               any,
    output logic [2:0]         index
);

    // Scan from the highest index down so the lowest set bit is the last one written
    always_comb begin
        any   = |pend;
        index = 3'd0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (pend[i]) begin
                index = 3'(i);
            end
        end
    end

endmodule

// File: rtl/dmg_irq_ctrl.sv
// DMG interrupt controller: IF/IE registers, IME with delayed EI, and a two-phase dispatch handshake.
module dmg_irq_ctrl
    import dmg_irq_pkg::*;
(
    input  logic       CLK,
    input  logic       nRESET,
    input  logic [4:0] IRQ_REQ,
    input  logic       REG_SEL,
    input  logic       REG_WR,
    input  logic [7:0] REG_WDATA,
    output logic [7:0] REG_RDATA,
    input  logic       EI,
    input  logic       DI,
    input  logic       RETI,
    input  logic       INSTR_DONE,
    input  logic       INT_ACK,
    input  logic       VEC_REQ,
    output logic       INT_PEND,
    output logic       WAKE,
    output logic       STOP_WAKE,
    output logic [7:0] VECTOR,
    output logic       VEC_VALID
);

    logic [IRQ_NUM-1:0] if_reg, if_next;
    logic [7:0]         ie_reg;
    logic               ime_reg, ime_next;
    logic               ei_armed_reg, ei_armed_next;
    irq_state_t         state_reg, state_next;
    logic [7:0]         vector_reg;

    logic [IRQ_NUM-1:0] pending;
    logic               pend_any;
    logic [2:0]         pend_idx;
    logic               ack_accept;
    logic               vec_take;
    logic [IRQ_NUM-1:0] dispatch_clr;
    logic               if_wr;
    logic               ie_wr;

    assign pending = if_reg & ie_reg[IRQ_NUM-1:0];

    dmg_irq_prio u_prio (
        .pend  (pending),
        .any   (pend_any),
        .index (pend_idx)
    );

    assign if_wr      = REG_WR & (REG_SEL == REG_IF);
    assign ie_wr      = REG_WR & (REG_SEL == REG_IE);
    assign ack_accept = INT_ACK & INT_PEND;
    assign vec_take   = (state_reg == ACKED) & VEC_REQ;

    // One-hot clear of the selected source, only when something is actually pending
    assign dispatch_clr = (vec_take && pend_any) ? IRQ_NUM'(5'b00001 << pend_idx) : '0;

    // Per-bit IF update: write, then dispatch clear, then a new request always wins
    generate
        for (genvar gi = 0; gi < IRQ_NUM; gi++) begin : g_if_bit
            assign if_next[gi] = ((if_wr ? REG_WDATA[gi] : if_reg[gi]) & ~dispatch_clr[gi])
                               | IRQ_REQ[gi];
        end
    endgenerate

    // Master enable: ack > DI > RETI > EI > promotion of an EI armed in an earlier cycle
    always_comb begin
        ime_next      = ime_reg;
        ei_armed_next = ei_armed_reg;
        if (ack_accept) begin
            ime_next      = 1'b0;
            ei_armed_next = 1'b0;
        end else if (DI) begin
            ime_next      = 1'b0;
            ei_armed_next = 1'b0;
        end else if (RETI) begin
            ime_next      = 1'b1;
            ei_armed_next = 1'b0;
        end else if (EI) begin
            ei_armed_next = 1'b1;
        end else if (ei_armed_reg && INSTR_DONE) begin
            ime_next      = 1'b1;
            ei_armed_next = 1'b0;
        end
    end

    // Dispatch FSM next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ack_accept) state_next = ACKED;
            ACKED:   if (VEC_REQ)    state_next = VECOUT;
            VECOUT:                  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Dispatch FSM outputs and status lines
    always_comb begin
        INT_PEND  = ime_reg & (|pending) & (state_reg == IDLE);
        VEC_VALID = (state_reg == VECOUT);
    end

    // All controller state, cleared by the active-low synchronous reset
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            if_reg       <= '0;
            ie_reg       <= 8'h00;
            ime_reg      <= 1'b0;
            ei_armed_reg <= 1'b0;
            state_reg    <= IDLE;
            vector_reg   <= VEC_CANCEL;
        end else begin
            if_reg       <= if_next;
            ime_reg      <= ime_next;
            ei_armed_reg <= ei_armed_next;
            state_reg    <= state_next;
            if (ie_wr) begin
                ie_reg <= REG_WDATA;
            end
            if (vec_take) begin
                vector_reg <= pend_any ? irq_vector(pend_idx) : VEC_CANCEL;
            end
        end
    end

    assign WAKE      = |pending;
    assign STOP_WAKE = IRQ_REQ[IRQ_JOYPAD];
    assign VECTOR    = vector_reg;
    assign REG_RDATA = (REG_SEL == REG_IE) ? ie_reg : {3'b111, if_reg};

endmodule
